// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, owner encodings and line geometry for the memory request arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RDATA, WRESP} state_t;
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;
  localparam int LINE_OFF_BITS = 4;
  localparam logic [1:0] REFILL_LEN = 2'd3;
endpackage

// File: rtl/mem_req_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the side not served last wins
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_en,
  output logic       o_valid,
  output logic       o_win
);
  assign o_valid = i_en & |i_req;
  assign o_win   = &i_req ? ~i_last : i_req[OWNER_DATA];
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one external memory bus between I-side and D-side, one transaction at a time
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int DATA_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cache,
  output logic        inst_gnt,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  output logic        inst_rlast,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic        data_cache,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  output logic        data_rlast,
  output logic        data_wdone,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  input  logic        bus_bvalid
);
  localparam logic LAST_RST = (DATA_FIRST != 0) ? OWNER_INST : OWNER_DATA;
  localparam logic [1:0] LINE_LEN = 2'(LINE_WORDS - 1);

  state_t      r_state, w_next;
  logic        r_owner, r_last;
  logic [1:0]  r_cnt;
  logic        r_bus_req, r_bus_wr;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [1:0]  r_bus_len;
  logic [3:0]  r_bus_wstrb;
  logic        w_pick, w_win, w_wr, w_refill, w_rv, w_beat_last, w_done, w_acked;
  logic [31:0] w_addr;

  rr_arb2 u_rr (
    .i_req   ({data_req, inst_req}),
    .i_last  (r_last),
    .i_en    (r_state == IDLE),
    .o_valid (w_pick),
    .o_win   (w_win)
  );

  assign w_wr        = w_win & data_wr;
  assign w_refill    = w_win ? (data_cache & ~data_wr) : inst_cache;
  assign w_addr      = w_win ? data_addr : inst_addr;
  assign w_rv        = (r_state == RDATA) & bus_rvalid;
  assign w_beat_last = w_rv & (r_cnt == r_bus_len);
  assign w_acked     = (r_state == REQ) & bus_ack;
  assign w_done      = w_beat_last | ((r_state == WRESP) & bus_bvalid);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state: request, wait for ack, then collect beats or the write response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_pick ? REQ : IDLE;
      REQ:     w_next = bus_ack ? (r_bus_wr ? WRESP : RDATA) : REQ;
      RDATA:   w_next = w_beat_last ? IDLE : RDATA;
      WRESP:   w_next = bus_bvalid ? IDLE : WRESP;
      default: w_next = IDLE;
    endcase
  end

  // outputs: grants, beats and write completion steered to the owning side only
  always_comb begin
    inst_gnt    = w_acked & (r_owner == OWNER_INST);
    data_gnt    = w_acked & (r_owner == OWNER_DATA);
    inst_rvalid = w_rv & (r_owner == OWNER_INST);
    data_rvalid = w_rv & (r_owner == OWNER_DATA);
    inst_rlast  = w_beat_last & (r_owner == OWNER_INST);
    data_rlast  = w_beat_last & (r_owner == OWNER_DATA);
    inst_rdata  = ((r_state == RDATA) & (r_owner == OWNER_INST)) ? bus_rdata : '0;
    data_rdata  = ((r_state == RDATA) & (r_owner == OWNER_DATA)) ? bus_rdata : '0;
    data_wdone  = (r_state == WRESP) & bus_bvalid;
  end

  // latch the picked request into the bus fields, track beats and the last-served side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWNER_INST;
      r_last      <= LAST_RST;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_len   <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
    end else begin
      if (w_pick) begin
        r_owner     <= w_win;
        r_bus_req   <= 1'b1;
        r_bus_wr    <= w_wr;
        r_bus_addr  <= w_refill ? {w_addr[31:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}} : w_addr;
        r_bus_len   <= w_refill ? LINE_LEN : 2'd0;
        r_bus_wdata <= w_wr ? data_wdata : '0;
        r_bus_wstrb <= w_wr ? data_wstrb : '0;
      end
      if (w_acked) r_bus_req <= 1'b0;
      if (w_rv) r_cnt <= w_beat_last ? 2'd0 : r_cnt + 2'd1;
      if (w_done) r_last <= r_owner;
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_wr    = r_bus_wr;
  assign bus_addr  = r_bus_addr;
  assign bus_len   = r_bus_len;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed table plus hand sequences for arbitration and reset corners
module tb_mem_req_arbiter;
  localparam logic [7:0] IG = 8'h80, IV = 8'h40, IL = 8'h20, DG = 8'h10;
  localparam logic [7:0] DV = 8'h08, DL = 8'h04, WD = 8'h02, BR = 8'h01;

  typedef struct {
    logic ir; logic [31:0] ia; logic ic;
    logic dr; logic dw; logic [31:0] da; logic dc; logic [31:0] wd; logic [3:0] ws;
    logic ak; logic rv; logic [31:0] rd; logic bv;
    logic [7:0] ef; logic ew; logic [31:0] ea; logic [1:0] el; logic [3:0] es;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic inst_req = 0, inst_cache = 0, data_req = 0, data_wr = 0, data_cache = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, bus_rdata = 0;
  logic [3:0] data_wstrb = 0;
  logic bus_ack = 0, bus_rvalid = 0, bus_bvalid = 0;
  logic inst_gnt, inst_rvalid, inst_rlast, data_gnt, data_rvalid, data_rlast, data_wdone;
  logic bus_req, bus_wr;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic [1:0] bus_len;
  logic [3:0] bus_wstrb;
  int errs = 0, n_chk = 0;
  vec_t tbl[29];

  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cache(inst_cache),
    .inst_gnt(inst_gnt), .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rlast(inst_rlast),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_cache(data_cache),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_gnt(data_gnt), .data_rdata(data_rdata),
    .data_rvalid(data_rvalid), .data_rlast(data_rlast), .data_wdone(data_wdone),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_len(bus_len),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .bus_bvalid(bus_bvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] flags();
    return {inst_gnt, inst_rvalid, inst_rlast, data_gnt, data_rvalid, data_rlast, data_wdone, bus_req};
  endfunction

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic ic, logic dr, logic dw, logic [31:0] da,
                              logic dc, logic [31:0] wd, logic [3:0] ws, logic ak, logic rv,
                              logic [31:0] rd, logic bv, logic [7:0] ef, logic ew, logic [31:0] ea,
                              logic [1:0] el, logic [3:0] es);
    vec_t x;
    x.ir = ir; x.ia = ia; x.ic = ic; x.dr = dr; x.dw = dw; x.da = da; x.dc = dc; x.wd = wd; x.ws = ws;
    x.ak = ak; x.rv = rv; x.rd = rd; x.bv = bv; x.ef = ef; x.ew = ew; x.ea = ea; x.el = el; x.es = es;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = 0; inst_cache = 0;
    data_req = 0; data_wr = 0; data_addr = 0; data_cache = 0; data_wdata = 0; data_wstrb = 0;
    bus_ack = 0; bus_rvalid = 0; bus_rdata = 0; bus_bvalid = 0;
  endtask

  task automatic drive(input vec_t x);
    inst_req = x.ir; inst_addr = x.ia; inst_cache = x.ic;
    data_req = x.dr; data_wr = x.dw; data_addr = x.da; data_cache = x.dc;
    data_wdata = x.wd; data_wstrb = x.ws;
    bus_ack = x.ak; bus_rvalid = x.rv; bus_rdata = x.rd; bus_bvalid = x.bv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1; bus_rvalid = 1; bus_bvalid = 1; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    #1;
    chk("reset flags", 64'(flags()), 64'h0);
    chk("reset bus fields", 64'({bus_wr, bus_addr, bus_len, bus_wstrb}), 64'h0);
    chk("reset wdata/rdata", {bus_wdata, inst_rdata | data_rdata}, 64'h0);
    @(negedge clk);
    clear_inputs();
    rst = 0;
  endtask

  task automatic wait_gnt(output logic win, output logic got);
    got = 0; win = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      bus_ack = bus_req;
      #1;
      if (inst_gnt | data_gnt) begin
        got = 1; win = data_gnt;
        chk("single grant", 64'(inst_gnt & data_gnt), 64'h0);
      end
    end
  endtask

  initial begin
    logic w, got;
    tbl[0]  = mk(1, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BR, 0, 32'h1230, 3, 0);
    tbl[2]  = mk(1, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, IG | BR, 0, 32'h1230, 3, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA0, 0, IV, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA1, 0, IV, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA2, 0, IV, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA3, 0, IV | IL, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 1, 32'h10, 0, 32'hDEADBEEF, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 1, 32'h10, 0, 32'hDEADBEEF, 4'h3, 0, 0, 0, 0, BR, 1, 32'h10, 0, 4'h3);
    tbl[10] = mk(0, 0, 0, 1, 1, 32'h10, 0, 32'hDEADBEEF, 4'h3, 1, 0, 0, 0, DG | BR, 1, 32'h10, 0, 4'h3);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, WD, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 1, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 32'h1FC0_0004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 32'h1FC0_0004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BR, 0, 32'h1FC0_0004, 0, 0);
    tbl[16] = mk(1, 32'h1FC0_0004, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, IG | BR, 0, 32'h1FC0_0004, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0, IV | IL, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 1, 0, 32'h2008, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 1, 0, 32'h2008, 1, 0, 0, 1, 0, 0, 0, DG | BR, 0, 32'h2000, 3, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD0, 0, DV, 0, 0, 0, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD1, 0, DV, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD2, 0, DV, 0, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hD3, 0, DV | DL, 0, 0, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[26] = mk(0, 0, 0, 1, 1, 32'h44, 1, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(0, 0, 0, 1, 1, 32'h44, 1, 32'h1234_5678, 4'hF, 1, 0, 0, 0, DG | BR, 1, 32'h44, 0, 4'hF);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, WD, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d flags", i), 64'(flags()), 64'(tbl[i].ef));
      if (tbl[i].ef[0]) begin
        chk($sformatf("v%0d bus fields", i), 64'({bus_wr, bus_addr, bus_len, bus_wstrb}),
            64'({tbl[i].ew, tbl[i].ea, tbl[i].el, tbl[i].es}));
        if (tbl[i].ew) chk($sformatf("v%0d wdata", i), 64'(bus_wdata), 64'(tbl[i].wd));
      end
      if ((tbl[i].ef & IV) != 0) chk($sformatf("v%0d inst_rdata", i), 64'(inst_rdata), 64'(tbl[i].rd));
      if ((tbl[i].ef & DV) != 0) chk($sformatf("v%0d data_rdata", i), 64'(data_rdata), 64'(tbl[i].rd));
    end

    do_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w, got);
      chk($sformatf("rr%0d granted", k), 64'(got), 64'h1);
      chk($sformatf("rr%0d owner", k), 64'(w), 64'((k % 2) == 0));
      @(negedge clk);
      bus_ack = 0; bus_rvalid = 1; bus_rdata = 32'(k);
      if (w) data_req = 0; else inst_req = 0;
      #1;
      chk($sformatf("rr%0d beat", k), 64'(flags()), 64'(w ? (DV | DL) : (IV | IL)));
      @(negedge clk);
      bus_rvalid = 0;
      inst_req = 1; data_req = 1;
    end

    do_reset();
    @(negedge clk);
    inst_req = 1; inst_cache = 1; inst_addr = 32'h1234;
    wait_gnt(w, got);
    chk("mid-rst inst granted", 64'({got, w}), 64'b10);
    @(negedge clk);
    bus_ack = 0; inst_req = 0; bus_rvalid = 1; bus_rdata = 32'hB0;
    @(negedge clk);
    bus_rdata = 32'hB1;
    @(negedge clk);
    rst = 1; bus_rdata = 32'hB2;
    #1;
    chk("mid-rst flags", 64'(flags()), 64'h0);
    chk("mid-rst rdata", 64'(inst_rdata), 64'h0);
    @(negedge clk);
    rst = 0; bus_rvalid = 0;
    data_req = 1; data_cache = 1; data_addr = 32'h3004;
    wait_gnt(w, got);
    chk("post-rst data granted", 64'({got, w}), 64'b11);
    chk("post-rst bus fields", 64'({bus_addr, bus_len}), 64'({32'h3000, 2'd3}));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus_ack = 0; data_req = 0; bus_rvalid = 1; bus_rdata = 32'hC0 + 32'(b);
      #1;
      chk($sformatf("post-rst beat%0d", b), 64'(flags()), 64'(b == 3 ? (DV | DL) : DV));
    end
    @(negedge clk);
    bus_rvalid = 0;
    #1;
    chk("post-rst idle", 64'(flags()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
